// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu_ctl codes, op field encodings and FSM states for serial_alu_n
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - one-bit ALU slice with operand inversion, ripple carry and SLT set output
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       carry_out,
    output logic       set,
    output logic       overflow
);

    logic a_i;
    logic b_i;
    logic sum;

    always_comb begin
        a_i       = a ^ ainvert;
        b_i       = b ^ binvert;
        sum       = a_i ^ b_i ^ carry_in;
        carry_out = (a_i & b_i) | (a_i & carry_in) | (b_i & carry_in);
        overflow  = carry_in ^ carry_out;
        // Sign of the true difference even when the subtraction overflows.
        set       = sum ^ overflow;
        case (op)
            OP_AND:  result = a_i & b_i;
            OP_OR:   result = a_i | b_i;
            OP_ADD:  result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_n.sv
// rtl/serial_alu_n.sv - iterative WIDTH-bit ALU, DIGIT bits per cycle; SERIAL_ALU_ZERO_FLAG_EN adds the zero output
module serial_alu_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             carry_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             carry_out_q, carry_out_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic [DIGIT:0]   chain_c;
    logic [DIGIT-1:0] chunk_a;
    logic [DIGIT-1:0] chunk_b;
    logic [DIGIT-1:0] chunk_r;
    logic [DIGIT-1:0] chunk_set;
    logic [DIGIT-1:0] chunk_ovf;
    logic             unused_slice_flags;

    assign chain_c[0] = carry_q;
    assign chunk_a    = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign chunk_b    = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign unused_slice_flags = ^{chunk_set, chunk_ovf};

    // less is tied low; the SLT bit is patched into result bit0 on the final chunk.
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        alu_bit_slice u_slice (
            .a         (chunk_a[i]),
            .b         (chunk_b[i]),
            .carry_in  (chain_c[i]),
            .ainvert   (ctl_q[3]),
            .binvert   (ctl_q[2]),
            .less      (1'b0),
            .op        (ctl_q[1:0]),
            .result    (chunk_r[i]),
            .carry_out (chain_c[i+1]),
            .set       (chunk_set[i]),
            .overflow  (chunk_ovf[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        ctl_d       = ctl_q;
        carry_d     = carry_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        carry_out_d = carry_out_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        zero_d      = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in1;
                    b_d     = in2;
                    ctl_d   = alu_ctl;
                    carry_d = alu_ctl[2];
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                    zero_d  = 1'b0;
`endif
                end
            end
            S_RUN: begin
                result_d[int'(cnt_q) * DIGIT +: DIGIT] = chunk_r;
                carry_d = chain_c[DIGIT];
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                zero_d  = ((cnt_q == '0) | zero_q) & (chunk_r == '0);
`endif
                if (cnt_q == LAST) begin
                    state_d     = S_DONE;
                    overflow_d  = (ctl_q[1:0] == OP_ADD) & chunk_ovf[DIGIT-1];
                    carry_out_d = (ctl_q[1:0] == OP_ADD) & chain_c[DIGIT];
                    if (ctl_q[1:0] == OP_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}}, chunk_set[DIGIT-1]};
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                        zero_d   = ~chunk_set[DIGIT-1];
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_out_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_alu_n.sv
// tb/tb_serial_alu_n.sv - scoreboard bench for serial_alu_n at WIDTH=8, DIGIT=2
module tb_serial_alu_n;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       alu_ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry_out;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    logic             zero;
`endif

    serial_alu_n #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .alu_ctl   (alu_ctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic       o;
        logic       c;
        logic       z;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, values on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v && q.size() > 0)
                chk("latency", cyc - q[0].acc, N);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.r);
                    chk("overflow", overflow, e.o);
                    chk("carry_out", carry_out, e.c);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
                    chk("zero", zero, e.z);
`endif
                end
            end
            prev_v = out_valid;
        end
    end

    // Called at posedge+1; returns at accept edge +1.
    task automatic issue(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic eo, input logic ec, input logic ez,
                         input bit push);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        alu_ctl  = ctl;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1      = 8'h00;
        in2      = 8'h00;
        if (push) begin
            e.r = er; e.o = eo; e.c = ec; e.z = ez; e.acc = cyc;
            q.push_back(e);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        alu_ctl   = '0;
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_carry_out", carry_out, 0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        chk("rst_zero", zero, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        issue(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1, 0, 0, 1);
        issue(ALU_SUB, 8'h05, 8'h07, 8'hFE, 0, 0, 0, 1);
        issue(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 1);
        issue(ALU_SLT, 8'h80, 8'h01, 8'h01, 0, 0, 0, 1);
        issue(ALU_SLT, 8'h01, 8'h80, 8'h00, 0, 0, 1, 1);
        issue(ALU_AND, 8'hAA, 8'hF0, 8'hA0, 0, 0, 0, 1);
        issue(ALU_OR,  8'hA0, 8'h05, 8'hA5, 0, 0, 0, 1);
        issue(ALU_NOR, 8'hF0, 8'h0F, 8'h00, 0, 0, 1, 1);

        // Back-pressure in DONE with a competing request on the input side.
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        issue(ALU_ADD, 8'h10, 8'h20, 8'h30, 0, 0, 0, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", out_valid, 1);
        alu_ctl  = ALU_ADD;
        in1      = 8'hFF;
        in2      = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_result", result, 8'h30);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("exit_out_valid", out_valid, 0);
        chk("exit_in_ready", in_ready, 1);
        chk("exit_result_kept", result, 8'h30);

        // Abort an operation on its second RUN cycle.
        issue(ALU_ADD, 8'h55, 8'h11, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_carry_out", carry_out, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(ALU_ADD, 8'h01, 8'h01, 8'h02, 0, 0, 0, 1);

        issue(ALU_SUB, 8'h33, 8'h33, 8'h00, 0, 1, 1, 1);
        issue(ALU_ADD, 8'h33, 8'h00, 8'h33, 0, 0, 0, 1);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
